// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO with a sticky overflow flag.
module uart_rx_fifo #(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          clear_overflow,
  output logic [DW-1:0] head_data,
  output logic          valid,
  output logic          overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] head;
  logic [FIFO_AW-1:0] tail;
  logic [CW-1:0]      count;
  logic               full;
  logic               pop_ok;
  logic               push_ok;
  logic               drop;

  // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign head_data = valid ? mem[head] : '0;

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + FIFO_AW'(1);
      if (pop_ok)  head <= head + FIFO_AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[tail] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT byte FIFO, with sticky error flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX,
  input  logic       read_data,
  input  logic       clear_errors,
  output logic [7:0] Data_RX,
  output logic       data_valid,
  output logic       frame_error,
  output logic       overflow,
  output logic       is_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  logic                      rx_m;
  logic                      rx_s;
  rx_state_t                 state;
  rx_state_t                 state_n;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_n;
  logic [BW-1:0]             bit_idx;
  logic [BW-1:0]             bit_n;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [UART_DATA_BITS-1:0] shift_n;
  logic                      push;
  logic                      fe_set;

  // Two-flop synchronizer on the asynchronous line, idling high.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // Receiver state, counters, shift register and sticky framing flag.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      frame_error <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      if (fe_set)            frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
    end
  end

  // Next-state logic: mid-bit sampling driven by the cycle counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) state_n = STOP;
          else                     bit_n   = bit_idx + BW'(1);
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign is_busy = (state != IDLE);

  uart_rx_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (UART_DATA_BITS)
  ) u_fifo (
    .clk            (Clk),
    .rst            (Rst),
    .push           (push),
    .push_data      (shift_reg),
    .pop            (read_data),
    .clear_overflow (clear_errors),
    .head_data      (Data_RX),
    .valid          (data_valid),
    .overflow       (overflow)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: queue-based reference model plus per-cycle compare.
module tb_uart_rx_buffered;

  localparam int C     = 16;
  localparam int HALF  = C / 2;
  localparam int DEPTH = 16;
  // Edges from the pin falling to the stop-bit sample: 2 sync + 1 leave IDLE + half bit + 9 bits.
  localparam int STOP_EDGE = 3 + HALF + 9 * C;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RX = 1'b1;
  logic       read_data = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] Data_RX;
  logic       data_valid;
  logic       frame_error;
  logic       overflow;
  logic       is_busy;

  uart_rx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_AW      (4)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .RX           (RX),
    .read_data    (read_data),
    .clear_errors (clear_errors),
    .Data_RX      (Data_RX),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .overflow     (overflow),
    .is_busy      (is_busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         edge_no;
    logic [7:0] b;
    bit         bad;
  } ev_t;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  ev_t        evq[$];
  logic [7:0] mq[$];
  bit         m_fe = 1'b0;
  bit         m_ov = 1'b0;
  int         busy_from = -1;
  int         busy_until = -1;
  bit         rand_pop = 1'b0;
  int         pop_edge = -1;
  int         rise_cyc = -1;
  logic       prev_dv = 1'b0;

  ev_t ev;
  bit  do_pop;
  bit  do_push;
  bit  new_fe;
  bit  new_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte queue and sticky flags advanced on every rising edge.
  always @(posedge Clk) begin
    cyc++;
    if (Rst) begin
      mq.delete();
      evq.delete();
      m_fe       = 1'b0;
      m_ov       = 1'b0;
      busy_from  = -1;
      busy_until = -1;
    end else begin
      do_pop  = read_data && (mq.size() > 0);
      do_push = 1'b0;
      new_fe  = 1'b0;
      new_ov  = 1'b0;
      if (evq.size() > 0 && evq[0].edge_no == cyc) begin
        ev = evq.pop_front();
        if (ev.bad)                              new_fe  = 1'b1;
        else if (mq.size() == DEPTH && !do_pop)  new_ov  = 1'b1;
        else                                     do_push = 1'b1;
      end
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(ev.b);
      if (new_fe)            m_fe = 1'b1;
      else if (clear_errors) m_fe = 1'b0;
      if (new_ov)            m_ov = 1'b1;
      else if (clear_errors) m_ov = 1'b0;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge Clk) begin
    if (cyc >= 1) begin
      check("data_valid", 32'(data_valid), 32'(mq.size() != 0));
      check("Data_RX", 32'(Data_RX), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      check("frame_error", 32'(frame_error), 32'(m_fe));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("is_busy", 32'(is_busy), 32'((cyc >= busy_from) && (cyc < busy_until)));
    end
    if (data_valid === 1'b1 && prev_dv === 1'b0 && rise_cyc < 0) rise_cyc = cyc;
    prev_dv = data_valid;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    read_data = rand_pop ? ($urandom_range(3) == 0) : (cyc == pop_edge - 1);
  endtask

  task automatic pop1();
    read_data = 1'b1;
    tick();
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_bad);
    int n;
    n = cyc;
    evq.push_back(ev_t'{n + STOP_EDGE, b, stop_bad});
    busy_from  = n + 3;
    busy_until = stop_bad ? n + 10 * C + 3 : n + STOP_EDGE;
    RX = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (C) tick();
    end
    RX = !stop_bad;
    repeat (C) tick();
    RX = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] b;
    repeat (3) tick();
    Rst = 1'b0;
    tick();
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset Data_RX", 32'(Data_RX), 32'h0);
    check("reset is_busy", 32'(is_busy), 32'h0);
    check("reset flags", {30'h0, frame_error, overflow}, 32'h0);

    // Single frame at nominal baud.
    n = cyc;
    send(8'hA5, 1'b0);
    check("A5 latency", 32'(rise_cyc - n), 32'd155);
    check("A5 data", 32'(Data_RX), 32'hA5);
    check("A5 flags", {30'h0, frame_error, overflow}, 32'h0);
    pop1();
    check("A5 popped", 32'(data_valid), 32'h0);

    // Back-to-back frames overflow the FIFO; drain in order.
    for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
    tick();
    check("overflow set", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check("drain order", 32'(Data_RX), 32'(i));
      pop1();
    end
    check("drained empty", 32'(data_valid), 32'h0);
    pulse_clear();
    check("overflow cleared", 32'(overflow), 32'h0);

    // Framing error, recovery.
    send(8'h3C, 1'b1);
    repeat (4) tick();
    check("frame_error set", 32'(frame_error), 32'h1);
    check("bad byte dropped", 32'(data_valid), 32'h0);
    pulse_clear();
    check("frame_error cleared", 32'(frame_error), 32'h0);
    send(8'h55, 1'b0);
    check("after error data", 32'(Data_RX), 32'h55);
    pop1();

    // Short glitch on an idle line.
    n = cyc;
    busy_from  = n + 3;
    busy_until = n + 3 + HALF;
    RX = 1'b0;
    repeat (5) tick();
    RX = 1'b1;
    repeat (30) tick();
    check("glitch no byte", 32'(data_valid), 32'h0);
    check("glitch no flags", {30'h0, frame_error, overflow}, 32'h0);

    // Reset in the middle of a frame.
    send(8'h12, 1'b0);
    busy_from  = cyc + 3;
    busy_until = cyc + 100000;
    RX = 1'b0;
    repeat (C) tick();
    RX = 1'b1;
    repeat (4 * C) tick();
    Rst = 1'b1;
    repeat (2) tick();
    Rst = 1'b0;
    check("midreset data_valid", 32'(data_valid), 32'h0);
    check("midreset Data_RX", 32'(Data_RX), 32'h0);
    check("midreset busy", 32'(is_busy), 32'h0);
    repeat (6 * C) tick();
    send(8'h81, 1'b0);
    check("after reset data", 32'(Data_RX), 32'h81);
    pop1();

    // Full FIFO, push coinciding with a pop.
    for (int i = 0; i < 16; i++) send(8'($urandom_range(255)), 1'b0);
    pop_edge = cyc + STOP_EDGE;
    send(8'h77, 1'b0);
    pop_edge = -1;
    tick();
    check("simultaneous no overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) begin
      b = Data_RX;
      pop1();
    end
    check("77 last", 32'(b), 32'h77);
    check("full drained", 32'(data_valid), 32'h0);

    // Randomized traffic with random pops, framing errors and clears.
    rand_pop = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bit bad;
      bad = ($urandom_range(5) == 0);
      send(8'($urandom_range(255)), bad);
      repeat ((bad ? 2 : 0) + $urandom_range(12)) tick();
      if ($urandom_range(3) == 0) pulse_clear();
    end
    rand_pop = 1'b0;
    for (int i = 0; i < 40 && data_valid; i++) pop1();
    tick();
    check("random drained", 32'(data_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered UART receiver, the receive-side counterpart to the team's buffered UART transmitter. Samples an asynchronous 8N1 serial line in the system clock domain, recovers bytes LSB-first, and queues them in a 16-entry FIFO for a host-side reader with a pop handshake. Framing errors and FIFO overflow are flagged with sticky status bits.

## Interface
- CLKS_PER_BIT, 868: system clock cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW = 16.
- Clk  input  1  system clock; all logic on rising edge. Single clock, no separate UART clock.
- Rst  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial line; idle high.
- read_data  input  1  pop strobe; removes the head byte when data_valid is high.
- clear_errors  input  1  one-cycle strobe that clears frame_error and overflow.
- Data_RX  output  8  head-of-FIFO byte (first-word fall-through); valid only while data_valid is high.
- data_valid  output  1  FIFO non-empty.
- frame_error  output  1  sticky; a stop bit was sampled low.
- overflow  output  1  sticky; a good byte was dropped because the FIFO was full.
- is_busy  output  1  receiver FSM not in IDLE.

## Operation
- Synchronizer: RX passes through 2 flip-flops (reset value 1); all FSM logic uses the synchronized value rx_s.
- Bit counter: 0 to CLKS_PER_BIT-1. Bit index: 0 to 7.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s == 0, clear the bit counter and go to START.
  - START: at counter == CLKS_PER_BIT/2 - 1 (mid start bit), sample rx_s.
    - If 0: go to DATA.
    - If 1: glitch, return to IDLE. No flag is raised.
  - DATA: sample every CLKS_PER_BIT cycles at mid-bit and shift in LSB-first (shift_reg <= {rx_s, shift_reg[7:1]}). After bit 7, go to STOP.
  - STOP: sample at mid stop bit.
    - If 1: push shift_reg to the FIFO and go to IDLE.
    - If 0: set frame_error, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This handles a line break without re-triggering.
- FIFO: head/tail pointers of FIFO_AW bits with natural wrap, plus a count of FIFO_AW+1 bits.
  - full = (count == 2^FIFO_AW).
  - data_valid = (count != 0).
- Push while full with no pop in the same cycle: byte dropped, overflow set, FIFO unchanged.
- Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
- Pop on empty: ignored; pointers unchanged.
- Push and pop in the same cycle when empty: count goes to 1. data_valid stays low in that cycle and the pop has no effect.
- clear_errors in the same cycle as a new error: the error wins and the flag stays set.
- Reset values:
  - FSM = IDLE; pointers and count = 0.
  - data_valid = 0, frame_error = 0, overflow = 0, is_busy = 0.
  - Data_RX = 8'h00 (memory is not reset; Data_RX is forced to 0 when empty).
- Rst mid-frame: the partial byte is lost. After reset the FSM is in IDLE, and a still-low line re-triggers START. That frame normally ends in a frame error and WAIT_HIGH, which is acceptable.

## Timing
- Start detect latency: 2 cycles (synchronizer) after RX falls, plus 1 cycle to leave IDLE.
- Sample points relative to the detected falling edge: start bit at CLKS_PER_BIT/2; data bit k at (k+1.5)·CLKS_PER_BIT; stop bit at 9.5·CLKS_PER_BIT (±1 cycle).
- data_valid rises the cycle after the stop-bit sample, about 9.5·CLKS_PER_BIT + 3 cycles after the pin falls.
- The FSM is back in IDLE in time for a back-to-back start bit that immediately follows a stop bit.
- Pop: Data_RX shows the next byte the cycle after read_data.
- Tolerates ±4% baud mismatch at the default CLKS_PER_BIT.

## Structure
- Shared package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS = 8;
  - UART_DEFAULT_CLKS_PER_BIT = 868.
- One natural sub-module, uart_rx_fifo: synchronous FWFT FIFO parameterised by FIFO_AW. It implements the push/pop/full/empty/overflow rules above and is reusable on the TX side.

## Test plan
Run all scenarios with CLKS_PER_BIT = 16.
- Single frame 0xA5 at nominal baud → data_valid rises about 155 cycles after the start edge; Data_RX = 0xA5; no flags. Pop → data_valid = 0.
- 20 back-to-back frames 0x00..0x13, no pops → FIFO holds 0x00..0x0F in order; overflow = 1. Draining yields exactly 16 bytes, and pointers wrap correctly.
- Frame 0x3C with the stop bit driven low, then line high → frame_error = 1; no byte queued. clear_errors → frame_error = 0. The next frame 0x55 is received correctly.
- 5-cycle low glitch on idle RX → returns to IDLE; no byte, no flags; is_busy high only during the glitch window.
- Rst asserted at data bit 4 of frame 0xFF → all outputs at reset values. The following clean frame 0x81 is received as 0x81.
- FIFO full with read_data held high while frame 0x77 completes → the push and the pop happen in the same cycle; overflow stays 0; 0x77 is last in the queue.
